// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state type and counter-width helper for the serializer
package piso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Width of a counter that must hold values 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word handshake in, serial bit stream and strobes out
interface piso_serializer_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_first;
  logic              ser_last;
  logic              busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer_mod_counter.sv
// rtl/piso_serializer_mod_counter.sv - modulo-N up-counter with sync clear, enable and wrap flag
module mod_counter
  import piso_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = (cnt_q == W'(N - 1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage with qualifier/framing strobes and optional inter-word gap
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  piso_serializer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_GAP   = ST_GAP;

  localparam int BW = cnt_width(DATA_W);
  localparam int GN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GW = cnt_width(GAP_CYCLES + 1);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              ser_first_q, ser_first_d;
  logic              ser_last_q, ser_last_d;

  logic [BW-1:0]     bit_cnt;
  logic              bit_wrap;
  logic [GW-1:0]     gap_cnt;
  logic              gap_wrap;
  logic              in_shift, in_gap;
  logic              in_ready, accept;

  // The bit currently presented always sits at the outgoing end of shreg
  function automatic logic head(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? v[DATA_W-1] : v[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  assign in_shift = (state_q == S_SHIFT);
  assign in_gap   = (state_q == S_GAP);

  // Ready depends only on state and counters, never on in_valid
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE:  in_ready = 1'b1;
        S_SHIFT: in_ready = bit_wrap && (GAP_CYCLES == 0);
        S_GAP:   in_ready = (gap_cnt == GW'(GN - 1));
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = bus.in_valid && in_ready;

  mod_counter #(.N(DATA_W), .W(BW)) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .en_i   (in_shift),
    .cnt_o  (bit_cnt),
    .wrap_o (bit_wrap)
  );

  mod_counter #(.N(GN), .W(GW)) u_gap_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!in_gap),
    .en_i   (in_gap),
    .cnt_o  (gap_cnt),
    .wrap_o (gap_wrap)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = advance(shreg_q);
        if (bit_wrap) begin
          if (GAP_CYCLES > 0) state_d = S_GAP;
          else                state_d = accept ? S_SHIFT : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_wrap) state_d = accept ? S_SHIFT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) shreg_d = bus.in_data;

    // Outputs are precomputed from next state so they leave straight from flops
    ser_valid_d = (state_d == S_SHIFT);
    ser_out_d   = ser_valid_d ? head(shreg_d) : IDLE_LEVEL;
    ser_first_d = accept;
    ser_last_d  = in_shift && (bit_cnt == BW'(DATA_W - 2));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_first = ser_first_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed and randomized bench for piso_serializer across three parameter sets
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst [3];
  logic       vld [3];
  logic [3:0] dat [3];
  logic o_rdy [3], o_out [3], o_vld [3], o_fst [3], o_lst [3], o_bsy [3];

  // Unit 0: defaults. Unit 1: GAP_CYCLES=2, IDLE_LEVEL=1. Unit 2: LSB first.
  piso_serializer_if #(.DATA_W(4)) bus0 ();
  piso_serializer_if #(.DATA_W(4)) bus1 ();
  piso_serializer_if #(.DATA_W(4)) bus2 ();

  piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0))
    dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));
  piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .GAP_CYCLES(2), .IDLE_LEVEL(1'b1))
    dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));
  piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0))
    dut2 (.clk(clk), .reset(rst[2]), .bus(bus2));

  assign bus0.in_data = dat[0];  assign bus0.in_valid = vld[0];
  assign bus1.in_data = dat[1];  assign bus1.in_valid = vld[1];
  assign bus2.in_data = dat[2];  assign bus2.in_valid = vld[2];

  assign o_rdy[0] = bus0.in_ready; assign o_out[0] = bus0.ser_out; assign o_vld[0] = bus0.ser_valid;
  assign o_fst[0] = bus0.ser_first; assign o_lst[0] = bus0.ser_last; assign o_bsy[0] = bus0.busy;
  assign o_rdy[1] = bus1.in_ready; assign o_out[1] = bus1.ser_out; assign o_vld[1] = bus1.ser_valid;
  assign o_fst[1] = bus1.ser_first; assign o_lst[1] = bus1.ser_last; assign o_bsy[1] = bus1.busy;
  assign o_rdy[2] = bus2.in_ready; assign o_out[2] = bus2.ser_out; assign o_vld[2] = bus2.ser_valid;
  assign o_fst[2] = bus2.ser_first; assign o_lst[2] = bus2.ser_last; assign o_bsy[2] = bus2.busy;

  // Downstream 4-bit serial shift register fed from unit 0
  logic [3:0] ds_q;
  always @(posedge clk) begin
    if (rst[0])      ds_q <= 4'h0;
    else if (o_vld[0]) ds_q <= {ds_q[2:0], o_out[0]};
  end

  function automatic int gap_of(input int u);
    return (u == 1) ? 2 : 0;
  endfunction
  function automatic logic msb_of(input int u);
    return (u == 2) ? 1'b0 : 1'b1;
  endfunction
  function automatic logic idle_of(input int u);
    return (u == 1) ? 1'b1 : 1'b0;
  endfunction

  // Packed view {ser_out, ser_valid, ser_first, ser_last, busy, in_ready}
  function automatic logic [5:0] obs(input int u);
    return {o_out[u], o_vld[u], o_fst[u], o_lst[u], o_bsy[u], o_rdy[u]};
  endfunction

  task automatic test_reset();
    logic [5:0] e;
    for (int u = 0; u < 3; u++) begin rst[u] = 1'b1; vld[u] = 1'b1; dat[u] = 4'hF; end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      e = {idle_of(u), 5'b00000};
      total++;
      if (obs(u) !== e) begin bad++; $display("FAIL reset_hold u%0d got=%b want=%b", u, obs(u), e); end
      rst[u] = 1'b0; vld[u] = 1'b0;
    end
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      e = {idle_of(u), 5'b00001};
      total++;
      if (obs(u) !== e) begin bad++; $display("FAIL reset_release u%0d got=%b want=%b", u, obs(u), e); end
    end
  endtask

  task automatic test_single();
    logic [3:0] w;
    logic [5:0] e;
    w = 4'b1011;
    @(negedge clk);
    vld[0] = 1'b1; dat[0] = w;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vld[0] = 1'b0; dat[0] = 4'($urandom);
      e = {w[3-k], 1'b1, k == 0, k == 3, 1'b1, k == 3};
      total++;
      if (obs(0) !== e) begin bad++; $display("FAIL single_bit%0d got=%b want=%b", k, obs(0), e); end
    end
    @(negedge clk);
    e = 6'b000001;
    total++;
    if (obs(0) !== e) begin bad++; $display("FAIL single_idle got=%b want=%b", obs(0), e); end
    total++;
    if (ds_q !== 4'b1011) begin bad++; $display("FAIL downstream_word got=%b want=%b", ds_q, 4'b1011); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    logic [5:0] e;
    int k;
    @(negedge clk);
    vld[0] = 1'b1; dat[0] = 4'hA;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      if (t <= 8) begin
        w = (t <= 4) ? 4'hA : 4'h5;
        k = (t - 1) % 4;
        e = {w[3-k], 1'b1, k == 0, k == 3, 1'b1, k == 3};
      end else begin
        e = 6'b000001;
      end
      total++;
      if (obs(0) !== e) begin bad++; $display("FAIL b2b_t%0d got=%b want=%b", t, obs(0), e); end
      if (t <= 3)      dat[0] = 4'($urandom);
      else if (t == 4) dat[0] = 4'h5;
      else             vld[0] = 1'b0;
    end
  endtask

  task automatic test_gap();
    logic [3:0] w;
    logic [5:0] e;
    int k;
    @(negedge clk);
    vld[1] = 1'b1; dat[1] = 4'hA;
    for (int t = 1; t <= 13; t++) begin
      @(negedge clk);
      if (t <= 4 || (t >= 7 && t <= 10)) begin
        w = (t <= 4) ? 4'hA : 4'h5;
        k = (t <= 4) ? t - 1 : t - 7;
        e = {w[3-k], 1'b1, k == 0, k == 3, 1'b1, 1'b0};
      end else if (t == 5 || t == 11) begin
        e = 6'b100010;
      end else if (t == 6 || t == 12) begin
        e = 6'b100011;
      end else begin
        e = 6'b100001;
      end
      total++;
      if (obs(1) !== e) begin bad++; $display("FAIL gap_t%0d got=%b want=%b", t, obs(1), e); end
      if (t <= 5)      dat[1] = 4'($urandom);
      else if (t == 6) dat[1] = 4'h5;
      else             vld[1] = 1'b0;
    end
  endtask

  task automatic test_reset_midword();
    logic [3:0] w;
    logic [5:0] e;
    int k;
    @(negedge clk);
    vld[0] = 1'b1; dat[0] = 4'hF;
    @(negedge clk); vld[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    e = 6'b110010;
    total++;
    if (obs(0) !== e) begin bad++; $display("FAIL midword_bit2 got=%b want=%b", obs(0), e); end
    rst[0] = 1'b1;
    @(negedge clk);
    e = 6'b000000;
    total++;
    if (obs(0) !== e) begin bad++; $display("FAIL midword_abort got=%b want=%b", obs(0), e); end
    rst[0] = 1'b0;
    @(negedge clk);
    e = 6'b000001;
    total++;
    if (obs(0) !== e) begin bad++; $display("FAIL midword_ready got=%b want=%b", obs(0), e); end
    w = 4'h9;
    vld[0] = 1'b1; dat[0] = w;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      vld[0] = 1'b0;
      k = t - 1;
      e = {w[3-k], 1'b1, k == 0, k == 3, 1'b1, k == 3};
      total++;
      if (obs(0) !== e) begin bad++; $display("FAIL midword_next_t%0d got=%b want=%b", t, obs(0), e); end
    end
    @(negedge clk);
    total++;
    if (ds_q !== 4'h9) begin bad++; $display("FAIL midword_downstream got=%b want=%b", ds_q, 4'h9); end
  endtask

  task automatic test_lsb_first();
    logic [3:0] bits;
    logic [5:0] e;
    bits = 4'b1011;
    @(negedge clk);
    vld[2] = 1'b1; dat[2] = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vld[2] = 1'b0;
      e = {bits[k], 1'b1, k == 0, k == 3, 1'b1, k == 3};
      total++;
      if (obs(2) !== e) begin bad++; $display("FAIL lsb_bit%0d got=%b want=%b", k, obs(2), e); end
    end
  endtask

  // Reference: a word accepted at cycle a owns cycles a+1..a+4, then GAP idle cycles, and
  // the next word may be accepted at a+4+GAP.
  task automatic test_random(input int u, input int ncyc);
    bit         have;
    int         last_a, ready_at, k, g;
    logic [3:0] last_w, d;
    logic       v, ex_out, ex_vld, ex_fst, ex_lst, ex_bsy, ex_rdy;
    logic [5:0] e;
    have = 1'b0; last_a = 0; last_w = 4'h0; ready_at = 0; g = gap_of(u);
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      ex_rdy = (t >= ready_at);
      ex_out = idle_of(u); ex_vld = 1'b0; ex_fst = 1'b0; ex_lst = 1'b0;
      if (have && t <= last_a + 4) begin
        k = t - last_a - 1;
        ex_out = msb_of(u) ? last_w[3-k] : last_w[k];
        ex_vld = 1'b1; ex_fst = (k == 0); ex_lst = (k == 3);
      end
      ex_bsy = have && (t <= last_a + 4 + g);
      e = {ex_out, ex_vld, ex_fst, ex_lst, ex_bsy, ex_rdy};
      total++;
      if (obs(u) !== e) begin bad++; $display("FAIL random_u%0d_t%0d got=%b want=%b", u, t, obs(u), e); end
      v = (t < ncyc - 10) && ($urandom_range(0, 3) != 0);
      d = 4'($urandom);
      vld[u] = v; dat[u] = d;
      if (v && ex_rdy) begin
        have = 1'b1; last_a = t; last_w = d; ready_at = t + 4 + g;
      end
    end
    vld[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin rst[u] = 1'b1; vld[u] = 1'b0; dat[u] = 4'h0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_midword();
    test_lsb_first();
    test_random(0, 300);
    test_random(1, 300);
    test_random(2, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out stage placed directly upstream of the 4-bit serial shift register.
- Accepts a parallel word over a valid/ready handshake and emits it one bit per clock on ser_out, which drives the downstream serial_in.
- Supplies qualifier and framing strobes so downstream logic can tell live bits from idle.
- Supports back-to-back words with no bubble, or an optional fixed inter-word gap.

Parameters:
- DATA_W, 4: word width; legal values are 2 and above.
- MSB_FIRST, 1: 1 sends bit DATA_W-1 first; 0 sends bit 0 first.
- GAP_CYCLES, 0: idle cycles forced between consecutive words; legal values are 0 and above.
- IDLE_LEVEL, 0: value driven on ser_out whenever ser_valid=0.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  parallel word; sampled only on a handshake.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial bit to downstream serial_in (registered).
- ser_valid  out  1  ser_out carries a data bit (registered).
- ser_first  out  1  pulses on the first bit of each word (registered).
- ser_last  out  1  pulses on the last bit of each word (registered).
- busy  out  1  asserted in SHIFT or GAP.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: ser_out=IDLE_LEVEL, ser_valid=0, ser_first=0, ser_last=0, busy=0, state=IDLE, counters=0.
- in_ready is forced to 0 while reset is high.
- Handshake: a word is accepted when in_valid && in_ready at a rising edge.
  - in_data is captured into the shift register on that edge.
  - in_valid may drop without an accept; this has no effect.
  - in_data changes while in_ready=0 are ignored.
- Latency: word accepted at cycle N → first bit on ser_out at N+1, last bit at N+DATA_W.
- FSM states:
  - IDLE: in_ready=1. On accept → SHIFT with bit_cnt=0.
  - SHIFT: ser_valid=1; shift register advances one bit per cycle; bit_cnt counts 0..DATA_W-1.
    - ser_first=1 when bit_cnt=0; ser_last=1 when bit_cnt=DATA_W-1.
    - On the last-bit cycle with GAP_CYCLES=0: in_ready=1. Accept → reload, stay in SHIFT, bit_cnt=0 (zero bubble). No accept → IDLE.
    - On the last-bit cycle with GAP_CYCLES>0: → GAP with gap_cnt=0.
  - GAP: ser_valid=0, ser_out=IDLE_LEVEL. gap_cnt counts 0..GAP_CYCLES-1.
    - in_ready=1 only on the final GAP cycle. Accept → SHIFT; otherwise → IDLE.
    - Result: exactly GAP_CYCLES invalid cycles between words when the source is ready.
- in_ready is combinational from state and counters, not from in_valid, so there is no valid→ready loop.
- Bit order: MSB_FIRST=1 shifts left and takes the MSB; MSB_FIRST=0 shifts right and takes the LSB.
- Outside SHIFT, ser_out=IDLE_LEVEL and all strobes are 0.
- Counter widths: bit_cnt is $clog2(DATA_W); gap_cnt is $clog2(GAP_CYCLES+1), minimum 1.
- Reset mid-word: the word is aborted.
  - The next cycle shows reset values; no partial word resumes.
  - in_ready=1 on the first cycle after reset deasserts.
- Simultaneous reset and in_valid: reset wins and no word is accepted.

Decomposition:
- Package piso_pkg:
  - State enum typedef: IDLE, SHIFT, GAP.
  - Helper function for counter width: max(1, $clog2(n)).
- Sub-module mod_counter: modulo-N up-counter with sync clear, enable and wrap flag. Instantiated twice, for bit_cnt and gap_cnt.
- Shift register and FSM stay in the top module.

Test Plan:
1. Defaults; in_data=4'b1011, in_valid for one cycle at N → ser_out 1,0,1,1 on N+1..N+4; ser_valid=1 on N+1..N+4; ser_first at N+1; ser_last at N+4; in_ready=0 on N+1..N+3.
2. GAP_CYCLES=0; in_valid held high with 4'hA then 4'h5 → 8 contiguous valid bits 1010_0101; second accept at N+4; ser_valid never drops between words.
3. GAP_CYCLES=2, IDLE_LEVEL=1; 4'hA then 4'h5 → bits 1010, then 2 cycles with ser_valid=0 and ser_out=1, then 0101; in_ready high only on the second gap cycle.
4. Reset asserted while bit index 2 of 4'hF is on ser_out → next cycle ser_valid=0, ser_out=0, busy=0; after release, 4'h9 serialises as 1,0,0,1 with correct first/last strobes.
5. MSB_FIRST=0; in_data=4'b1011 → ser_out 1,1,0,1.
6. Output fed into the downstream 4-bit shift register; 4'b1011 sent with MSB_FIRST=1 → downstream register holds 4'b1011 on the cycle after ser_last.
